tcm_boot_loader: RTL and testbench

Boot-time sequencer for the ITCM/DTCM SRAMs. After reset it holds the core in reset, accepts a program image as a byte stream, packs it little-endian into 32-bit words and writes each word to the same address in both ITCM and DTCM. It then optionally zero-fills the rest of both memories, releases the core, and from then on passes the core's TCM ports straight through to the RAMs. It sits between `cpu_top`'s core-side TCM buses and the ITCM/DTCM RAM instances inside `srams`.

---
 rtl/tcm_boot_loader_if.sv | 53 +++++
 rtl/tcm_boot_loader.sv | 145 ++++++++++++++
 tb/tb_tcm_boot_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcm_boot_loader_if.sv
// Signal bundle for tcm_boot_loader: image byte stream, boot status, core-side TCM buses and RAM-side TCM buses.
// The loader takes the slave modport; the surrounding system (core, RAMs, image source) takes master.
interface tcm_boot_loader_if #(
    parameter int AW = 12
);
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          core_rst;
    logic          ld_done;
    logic          ld_err;

    logic          core_i_cs;
    logic          core_i_we;
    logic [3:0]    core_i_wem;
    logic [AW-1:0] core_i_addr;
    logic [31:0]   core_i_wdat;
    logic          core_d_cs;
    logic          core_d_we;
    logic [3:0]    core_d_wem;
    logic [AW-1:0] core_d_addr;
    logic [31:0]   core_d_wdat;

    logic          i_cs;
    logic          i_we;
    logic [3:0]    i_wem;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_wdat;
    logic          d_cs;
    logic          d_we;
    logic [3:0]    d_wem;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdat;

    modport slave (
        input  ld_valid, ld_data, ld_last,
        input  core_i_cs, core_i_we, core_i_wem, core_i_addr, core_i_wdat,
        input  core_d_cs, core_d_we, core_d_wem, core_d_addr, core_d_wdat,
        output ld_ready, core_rst, ld_done, ld_err,
        output i_cs, i_we, i_wem, i_addr, i_wdat,
        output d_cs, d_we, d_wem, d_addr, d_wdat
    );

    modport master (
        output ld_valid, ld_data, ld_last,
        output core_i_cs, core_i_we, core_i_wem, core_i_addr, core_i_wdat,
        output core_d_cs, core_d_we, core_d_wem, core_d_addr, core_d_wdat,
        input  ld_ready, core_rst, ld_done, ld_err,
        input  i_cs, i_we, i_wem, i_addr, i_wdat,
        input  d_cs, d_we, d_wem, d_addr, d_wdat
    );
endinterface

// File: rtl/tcm_boot_loader.sv
// Boot sequencer: packs an image byte stream into words written to both ITCM and DTCM, then releases the core.
// Define TCM_BOOT_LOADER_CLEAR_EN to zero-fill the unloaded remainder of both TCMs before release.
module tcm_boot_loader #(
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic               clk,
    input  logic               rst,
    tcm_boot_loader_if.slave   bus
);
    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [1:0]    state;
    logic [1:0]    byte_idx;
    logic [3:0]    lane_mask;
    logic [31:0]   asm_word;
    logic          last_seen;
    logic [AW-1:0] wptr;
    logic          err;

    logic          accept;
    logic          at_end;
    logic [1:0]    after_image;

    assign accept = (state == FILL) && bus.ld_valid;
    assign at_end = (wptr == LAST_ADDR);

    // An image that ends on the final word leaves nothing to clear.
    always_comb begin
        after_image = DONE;
`ifdef TCM_BOOT_LOADER_CLEAR_EN
        if (!at_end) after_image = CLEAR;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            byte_idx  <= '0;
            lane_mask <= '0;
            asm_word  <= '0;
            last_seen <= 1'b0;
            wptr      <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        asm_word[{byte_idx, 3'b000} +: 8] <= bus.ld_data;
                        lane_mask[byte_idx]               <= 1'b1;
                        byte_idx                          <= byte_idx + 2'd1;
                        last_seen                         <= bus.ld_last;
                        if (byte_idx == 2'd3 || bus.ld_last) state <= WRITE;
                    end
                end
                WRITE: begin
                    wptr      <= wptr + 1'b1;
                    byte_idx  <= '0;
                    lane_mask <= '0;
                    asm_word  <= '0;
                    if (last_seen) begin
                        state <= after_image;
                    end else if (at_end) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= FILL;
                    end
                end
`ifdef TCM_BOOT_LOADER_CLEAR_EN
                CLEAR: begin
                    wptr <= wptr + 1'b1;
                    if (at_end) state <= DONE;
                end
`endif
                default: ;
            endcase
        end
    end

    logic          ram_cs;
    logic [3:0]    ram_wem;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdat;

    always_comb begin
        ram_cs   = 1'b0;
        ram_wem  = '0;
        ram_addr = '0;
        ram_wdat = '0;
        case (state)
            WRITE: begin
                ram_cs   = 1'b1;
                ram_wem  = lane_mask;
                ram_addr = wptr;
                ram_wdat = asm_word;
            end
`ifdef TCM_BOOT_LOADER_CLEAR_EN
            CLEAR: begin
                ram_cs   = 1'b1;
                ram_wem  = '1;
                ram_addr = wptr;
            end
`endif
            default: ;
        endcase
    end

    assign bus.ld_ready = (state == FILL);
    assign bus.core_rst = (state != DONE);
    assign bus.ld_done  = (state == DONE);
    assign bus.ld_err   = err;

    // Once released, the core owns the RAMs with no added latency.
    always_comb begin
        if (state == DONE) begin
            bus.i_cs   = bus.core_i_cs;
            bus.i_we   = bus.core_i_we;
            bus.i_wem  = bus.core_i_wem;
            bus.i_addr = bus.core_i_addr;
            bus.i_wdat = bus.core_i_wdat;
            bus.d_cs   = bus.core_d_cs;
            bus.d_we   = bus.core_d_we;
            bus.d_wem  = bus.core_d_wem;
            bus.d_addr = bus.core_d_addr;
            bus.d_wdat = bus.core_d_wdat;
        end else begin
            bus.i_cs   = ram_cs;
            bus.i_we   = ram_cs;
            bus.i_wem  = ram_wem;
            bus.i_addr = ram_addr;
            bus.i_wdat = ram_wdat;
            bus.d_cs   = ram_cs;
            bus.d_we   = ram_cs;
            bus.d_wem  = ram_wem;
            bus.d_addr = ram_addr;
            bus.d_wdat = ram_wdat;
        end
    end
endmodule

// File: tb/tb_tcm_boot_loader.sv
// Self-checking bench for tcm_boot_loader (DEPTH=8); expected RAM write sequences come from a byte-list model.
`timescale 1ns/1ps
module tb_tcm_boot_loader;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
`ifdef TCM_BOOT_LOADER_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   wdat;
        logic [3:0]    wem;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tcm_boot_loader_if #(.AW(AW)) bus ();
    tcm_boot_loader #(.AW(AW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          mon_en   = 1'b0;
    wr_t         wlog[$];
    wr_t         exp_q[$];
    logic [7:0]  img[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM-side observer: logs every loader write and checks both TCMs see identical traffic.
    always @(negedge clk) begin
        if (mon_en && bus.ld_done !== 1'b1) begin
            if (bus.i_cs === 1'b1) begin
                wlog.push_back('{addr: bus.i_addr, wdat: bus.i_wdat, wem: bus.i_wem});
                chk("d_matches_i", {bus.d_cs, bus.d_we, bus.d_wem, bus.d_addr, bus.d_wdat},
                                   {bus.i_cs, bus.i_we, bus.i_wem, bus.i_addr, bus.i_wdat});
                chk("write_we", bus.i_we, 1'b1);
            end else begin
                chk("idle_outputs", {bus.i_we, bus.i_wem, bus.i_addr, bus.i_wdat,
                                     bus.d_cs, bus.d_we, bus.d_wem, bus.d_addr, bus.d_wdat}, '0);
            end
        end
    end

    // Expected write sequence: packed little-endian words, partial last word masked, optional zero tail.
    task automatic build_exp(input bit has_last);
        int unsigned n     = img.size();
        int unsigned words = (n + 3) / 4;
        wr_t e;
        if (words > DEPTH) words = DEPTH;
        exp_q.delete();
        for (int unsigned w = 0; w < words; w++) begin
            e.addr = w[AW-1:0];
            e.wdat = '0;
            e.wem  = '0;
            for (int unsigned b = 0; b < 4; b++) begin
                if (4 * w + b < n) begin
                    e.wdat[8*b +: 8] = img[4*w+b];
                    e.wem[b]         = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
        if (CLEAR_EN && has_last) begin
            for (int unsigned w = words; w < DEPTH; w++) begin
                e.addr = w[AW-1:0];
                e.wdat = '0;
                e.wem  = 4'hF;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_log(input string tag);
        int unsigned m;
        chk($sformatf("%s_write_count", tag), 64'(wlog.size()), 64'(exp_q.size()));
        m = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
        for (int unsigned k = 0; k < m; k++)
            chk($sformatf("%s_write%0d", tag, k), 64'(wlog[k]), 64'(exp_q[k]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ld_ready", bus.ld_ready, 1'b1);
        chk("rst_core_rst", bus.core_rst, 1'b1);
        chk("rst_ld_done", bus.ld_done, 1'b0);
        chk("rst_ld_err", bus.ld_err, 1'b0);
        chk("rst_ram_outputs", {bus.i_cs, bus.i_we, bus.i_wem, bus.i_addr, bus.i_wdat,
                                bus.d_cs, bus.d_we, bus.d_wem, bus.d_addr, bus.d_wdat}, '0);
        @(negedge clk);
        rst = 1'b0;
        wlog.delete();
        mon_en = 1'b1;
    endtask

    // Presents one byte after `gap` idle cycles; returns at the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b, input bit last, input int unsigned gap);
        int unsigned cyc = 0;
        bus.ld_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        bus.ld_last  = last;
        while (bus.ld_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("byte_accepted_in_time", bus.ld_ready, 1'b1);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.ld_data  = 8'($urandom);
    endtask

    task automatic send_img(input bit has_last, input bit gaps);
        for (int unsigned k = 0; k < img.size(); k++)
            send_byte(img[k], has_last && (k == img.size() - 1),
                      gaps ? (($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0) : 0);
    endtask

    // Called at the negedge of the final WRITE cycle.
    task automatic wait_done(input string tag, input int unsigned exp_lat);
        int unsigned cyc = 0;
        while (bus.ld_done !== 1'b1 && cyc < 200) begin
            chk($sformatf("%s_core_held", tag), bus.core_rst, 1'b1);
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("%s_done_latency", tag), 64'(cyc), 64'(exp_lat));
        chk($sformatf("%s_core_released", tag), bus.core_rst, 1'b0);
        chk($sformatf("%s_ready_low", tag), bus.ld_ready, 1'b0);
    endtask

    function automatic int unsigned release_lat(input int unsigned nbytes);
        int unsigned words = (nbytes + 3) / 4;
        return CLEAR_EN ? 1 + DEPTH - words : 1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int unsigned lens[3];
        logic [3:0]    wem_v;
        logic [AW-1:0] addr_v;
        logic [31:0]   dat_v;

        bus.ld_valid    = 1'b0;
        bus.ld_data     = 8'h00;
        bus.ld_last     = 1'b0;
        // Core-side buses carry junk during load; it must never reach the RAMs.
        bus.core_i_cs   = 1'b1;  bus.core_i_we = 1'b1;  bus.core_i_wem = 4'hA;
        bus.core_i_addr = 3'd5;  bus.core_i_wdat = 32'hDEADBEEF;
        bus.core_d_cs   = 1'b1;  bus.core_d_we = 1'b1;  bus.core_d_wem = 4'h5;
        bus.core_d_addr = 3'd6;  bus.core_d_wdat = 32'hCAFEF00D;

        do_reset();

        // Two words, back to back, with 5-cycle-per-word timing.
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int unsigned k = 0; k < 4; k++) send_byte(img[k], 1'b0, 0);
        chk("word_write_cycle_ready", bus.ld_ready, 1'b0);
        chk("word_write_cycle_cs", bus.i_cs, 1'b1);
        @(negedge clk);
        chk("word_ready_after_write", bus.ld_ready, 1'b1);
        for (int unsigned k = 4; k < 8; k++) send_byte(img[k], k == 7, 0);
        wait_done("two_words", release_lat(8));
        build_exp(1'b1);
        check_log("two_words");
        chk("two_words_err", bus.ld_err, 1'b0);

        // Partial last word.
        do_reset();
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_img(1'b1, 1'b0);
        wait_done("partial", release_lat(6));
        build_exp(1'b1);
        check_log("partial");

        // Random images with gaps and bytes held across WRITE; 9 puts last on lane 0, 32 fills DEPTH exactly.
        lens[0] = 9;
        lens[1] = 32;
        lens[2] = $urandom_range(1, 31);
        for (int unsigned t = 0; t < 3; t++) begin
            do_reset();
            img.delete();
            for (int unsigned k = 0; k < lens[t]; k++) img.push_back(8'($urandom));
            send_img(1'b1, 1'b1);
            wait_done($sformatf("gaps%0d", t), release_lat(lens[t]));
            build_exp(1'b1);
            check_log($sformatf("gaps%0d", t));
            chk($sformatf("gaps%0d_err", t), bus.ld_err, 1'b0);
        end

        // Overflow: DEPTH words without last, then further bytes are refused.
        do_reset();
        img.delete();
        for (int unsigned k = 0; k < 4 * DEPTH; k++) img.push_back(8'($urandom));
        send_img(1'b0, 1'b0);
        wait_done("overflow", 1);
        build_exp(1'b0);
        check_log("overflow");
        chk("overflow_err", bus.ld_err, 1'b1);
        chk("overflow_done", bus.ld_done, 1'b1);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h77;
        for (int unsigned k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("overflow_ready_stays_low", bus.ld_ready, 1'b0);
        end
        bus.ld_valid = 1'b0;

        // Reset from DONE re-holds the core; then reset mid-load and reload.
        do_reset();
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_img(1'b0, 1'b0);
        do_reset();
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_img(1'b1, 1'b0);
        wait_done("reload", release_lat(4));
        build_exp(1'b1);
        check_log("reload");
        chk("reload_word0", 64'(exp_q[0].wdat), 64'h00000000DDCCBBAA);

        // Passthrough in DONE: same-cycle, for both buses.
        @(negedge clk);
        bus.core_d_cs = 1'b1; bus.core_d_we = 1'b1; bus.core_d_wem = 4'b0100;
        bus.core_d_addr = 3'd3; bus.core_d_wdat = 32'h00FF0000;
        bus.core_i_cs = 1'b0; bus.core_i_we = 1'b0; bus.core_i_wem = 4'h0;
        bus.core_i_addr = 3'd1; bus.core_i_wdat = 32'h12345678;
        #1;
        chk("pass_d_fixed", {bus.d_cs, bus.d_we, bus.d_wem, bus.d_addr, bus.d_wdat},
                            {1'b1, 1'b1, 4'b0100, 3'd3, 32'h00FF0000});
        chk("pass_i_fixed", {bus.i_cs, bus.i_we, bus.i_wem, bus.i_addr, bus.i_wdat},
                            {1'b0, 1'b0, 4'h0, 3'd1, 32'h12345678});
        for (int unsigned k = 0; k < 6; k++) begin
            @(negedge clk);
            wem_v  = 4'($urandom);
            addr_v = AW'($urandom);
            dat_v  = $urandom;
            bus.core_i_cs = 1'($urandom); bus.core_i_we = 1'($urandom);
            bus.core_i_wem = wem_v; bus.core_i_addr = addr_v; bus.core_i_wdat = dat_v;
            bus.core_d_cs = 1'($urandom); bus.core_d_we = 1'($urandom);
            bus.core_d_wem = ~wem_v; bus.core_d_addr = ~addr_v; bus.core_d_wdat = ~dat_v;
            #1;
            chk("pass_i_random", {bus.i_wem, bus.i_addr, bus.i_wdat}, {wem_v, addr_v, dat_v});
            chk("pass_d_random", {bus.d_wem, bus.d_addr, bus.d_wdat}, {~wem_v, ~addr_v, ~dat_v});
            chk("pass_ctl_random", {bus.i_cs, bus.i_we, bus.d_cs, bus.d_we},
                                   {bus.core_i_cs, bus.core_i_we, bus.core_d_cs, bus.core_d_we});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
